// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: row/column lines toward the keypad
// and the decoded key event toward the consumer (hex/display chain).
interface keypad_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // master: the scanner itself
    modport master (
        input  rows,
        output cols, key_code, key_valid, key_held
    );

    // slave: keypad matrix plus downstream key consumer
    modport slave (
        output rows,
        input  cols, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks one active-low column at a time, samples
// the synchronized rows at the end of each column dwell, classifies each
// full scan as none/single/multi and debounces presses and releases.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no key accepted, waiting for a single-key scan
// ST_DEBOUNCE| same single key seen on cnt consecutive scans
// ST_PRESSED | key accepted and strobed; rollover keys are ignored
// ST_RELEASE | no key seen on cnt consecutive scans
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    keypad_if.master kp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

    // hit counts saturate at 2: anything above one key is just "multi"
    localparam logic [1:0] HITS_NONE  = 2'd0;
    localparam logic [1:0] HITS_ONE   = 2'd1;
    localparam logic [1:0] HITS_MULTI = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    logic [3:0]    rows_s1_q, rows_s2_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    cols_q;
    logic [1:0]    acc_cnt_q;
    logic [3:0]    acc_code_q;
    logic          scan_rdy_q;
    logic [1:0]    scan_cnt_q;
    logic [3:0]    scan_code_q;

    logic          scan_tick;
    logic [3:0]    row_hit;
    logic [2:0]    col_hits;
    logic [1:0]    col_row;
    logic [2:0]    hit_sum;
    logic [1:0]    merged_cnt;
    logic [3:0]    merged_code;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    // Dwell/column sequencing and merge of this column's hits into the scan accumulator
    always_comb begin
        scan_tick = (dwell_q == DWELL_LAST);
        dwell_d   = scan_tick ? '0 : dwell_q + DW'(1);
        col_d     = scan_tick ? col_q + 2'd1 : col_q;
        row_hit   = ~rows_s2_q;
        col_hits  = 3'(row_hit[0]) + 3'(row_hit[1]) + 3'(row_hit[2]) + 3'(row_hit[3]);
        col_row   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_hit[i]) col_row = 2'(i);
        end
        hit_sum     = {1'b0, acc_cnt_q} + col_hits;
        merged_cnt  = (hit_sum >= 3'd2) ? HITS_MULTI : hit_sum[1:0];
        merged_code = (acc_cnt_q == HITS_NONE) ? key_map(col_row, col_q) : acc_code_q;
    end

    // Row synchronizer, column drive and per-scan result capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rows_s1_q   <= 4'hF;
            rows_s2_q   <= 4'hF;
            dwell_q     <= '0;
            col_q       <= 2'd0;
            cols_q      <= 4'b1110;
            acc_cnt_q   <= HITS_NONE;
            acc_code_q  <= 4'h0;
            scan_rdy_q  <= 1'b0;
            scan_cnt_q  <= HITS_NONE;
            scan_code_q <= 4'h0;
        end else begin
            rows_s1_q  <= kp.rows;
            rows_s2_q  <= rows_s1_q;
            dwell_q    <= dwell_d;
            col_q      <= col_d;
            cols_q     <= ~(4'b0001 << col_d);
            scan_rdy_q <= 1'b0;
            if (scan_tick) begin
                if (col_q == 2'd3) begin
                    scan_cnt_q  <= merged_cnt;
                    scan_code_q <= merged_code;
                    scan_rdy_q  <= 1'b1;
                    acc_cnt_q   <= HITS_NONE;
                    acc_code_q  <= 4'h0;
                end else begin
                    acc_cnt_q  <= merged_cnt;
                    acc_code_q <= merged_code;
                end
            end
        end
    end

    // Debounce FSM: acts only on the cycle a completed scan result is presented
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (scan_rdy_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_cnt_q == HITS_ONE) begin
                        cand_d  = scan_code_q;
                        cnt_d   = CW'(1);
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_cnt_q == HITS_ONE && scan_code_q == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (scan_cnt_q == HITS_NONE) begin
                        cnt_d   = CW'(1);
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    if (scan_cnt_q == HITS_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_PRESSED;
                    end
                end
            endcase
        end
    end

    // FSM and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.cols      = cols_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans).
// The keypad model pulls row r low only while a pressed key's column is driven low.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] pressed;      // bit r*4+c = key at row r, column c held
    int          total;
    int          bad;
    int          strobes;
    logic        prev_valid;
    logic [3:0]  exp_q[$];
    logic [3:0]  got_code;

    keypad_if kp ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .kp    (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad matrix model
    always_comb begin
        logic [3:0] rows_v;
        rows_v = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k] && !kp.cols[k % 4]) rows_v[k / 4] = 1'b0;
        end
        kp.rows = rows_v;
    end

    // scoreboard: every strobe must be one cycle wide and match the oldest expected code
    always @(negedge clk) begin
        if (kp.key_valid) begin
            strobes = strobes + 1;
            total = total + 1;
            if (prev_valid) begin
                bad = bad + 1;
                $display("FAIL strobe_width: key_valid high on consecutive cycles, required one cycle");
            end
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_strobe: got key_code=%0h, required no strobe", kp.key_code);
            end else begin
                got_code = exp_q.pop_front();
                if (kp.key_code !== got_code) begin
                    bad = bad + 1;
                    $display("FAIL strobe_code: got %0h required %0h", kp.key_code, got_code);
                end
            end
        end
        prev_valid = kp.key_valid;
    end

    // hold reset for a few cycles, return at the negedge where it is released
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols;
        logic [3:0] one;
        do_reset();
        total++; if (kp.cols !== 4'b1110) begin bad++; $display("FAIL reset_cols: got %b required 1110", kp.cols); end
        total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", kp.key_valid); end
        total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b required 0", kp.key_held); end
        total++; if (kp.key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %0h required 0", kp.key_code); end
        one = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            exp_cols = ~(one << ((n / 4) % 4));
            total++;
            if (kp.cols !== exp_cols) begin
                bad++;
                $display("FAIL col_cycle n=%0d: got %b required %b", n, kp.cols, exp_cols);
            end
        end
        total++; if (kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin bad++; $display("FAIL idle_outputs: got valid=%b held=%b required 0 0", kp.key_valid, kp.key_held); end
    endtask

    task automatic test_single_press();
        int s0, first_n;
        do_reset();
        s0 = strobes;
        first_n = -1;
        exp_q.push_back(4'h5);
        pressed = 16'h0020;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (kp.key_valid && first_n < 0) first_n = n;
        end
        total++; if (first_n != 49) begin bad++; $display("FAIL press5_latency: got cycle %0d required 49", first_n); end
        total++; if (strobes - s0 != 1) begin bad++; $display("FAIL press5_count: got %0d strobes required 1", strobes - s0); end
        total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL press5_held: got %b required 1", kp.key_held); end
        total++; if (kp.key_code !== 4'h5) begin bad++; $display("FAIL press5_code: got %0h required 5", kp.key_code); end
        pressed = 16'h0000;
        repeat (80) @(negedge clk);
        total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL press5_release: got held=%b required 0", kp.key_held); end
        total++; if (kp.key_code !== 4'h5) begin bad++; $display("FAIL press5_code_hold: got %0h required 5", kp.key_code); end
    endtask

    task automatic test_bounce();
        int s0, first_n;
        do_reset();
        s0 = strobes;
        first_n = -1;
        exp_q.push_back(4'h9);
        pressed = 16'h0400;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (kp.key_valid && first_n < 0) first_n = n;
            if (n == 32) pressed = 16'h0000;
            if (n == 48) pressed = 16'h0400;
        end
        total++; if (first_n != 97) begin bad++; $display("FAIL bounce_latency: got cycle %0d required 97", first_n); end
        total++; if (strobes - s0 != 1) begin bad++; $display("FAIL bounce_count: got %0d strobes required 1", strobes - s0); end
        total++; if (kp.key_code !== 4'h9) begin bad++; $display("FAIL bounce_code: got %0h required 9", kp.key_code); end
        pressed = 16'h0000;
        repeat (80) @(negedge clk);
    endtask

    task automatic test_multi_key();
        int s0;
        s0 = strobes;
        pressed = 16'h0003;
        repeat (96) @(negedge clk);
        total++; if (strobes != s0) begin bad++; $display("FAIL multi_no_strobe: got %0d strobes required 0", strobes - s0); end
        total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL multi_held: got %b required 0", kp.key_held); end
        pressed = 16'h0000;
        repeat (32) @(negedge clk);
        exp_q.push_back(4'h5);
        pressed = 16'h0020;
        repeat (96) @(negedge clk);
        total++; if (strobes - s0 != 1) begin bad++; $display("FAIL rollover_first: got %0d strobes required 1", strobes - s0); end
        pressed = pressed | 16'h4000;
        repeat (96) @(negedge clk);
        total++; if (strobes - s0 != 1) begin bad++; $display("FAIL rollover_second: got %0d strobes required 1", strobes - s0); end
        total++; if (kp.key_held !== 1'b1 || kp.key_code !== 4'h5) begin bad++; $display("FAIL rollover_state: got held=%b code=%0h required 1 5", kp.key_held, kp.key_code); end
        pressed = 16'h0000;
        repeat (32) @(negedge clk);
        total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL release_early: got held=%b required 1", kp.key_held); end
        repeat (38) @(negedge clk);
        total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL release_late: got held=%b required 0", kp.key_held); end
    endtask

    task automatic test_release_repress();
        int s0, first_n, drop_n;
        do_reset();
        s0 = strobes;
        first_n = -1;
        drop_n = -1;
        exp_q.push_back(4'hA);
        pressed = 16'h0008;
        for (int n = 1; n <= 130; n++) begin
            @(negedge clk);
            if (kp.key_valid && first_n < 0) first_n = n;
            if (n >= 49 && kp.key_held !== 1'b1 && drop_n < 0) drop_n = n;
            if (n == 64) pressed = 16'h0000;
            if (n == 80) pressed = 16'h0008;
        end
        total++; if (first_n != 49) begin bad++; $display("FAIL pressA_latency: got cycle %0d required 49", first_n); end
        total++; if (drop_n != -1) begin bad++; $display("FAIL repress_held: held dropped at cycle %0d, required stay high", drop_n); end
        total++; if (strobes - s0 != 1) begin bad++; $display("FAIL repress_count: got %0d strobes required 1", strobes - s0); end
        pressed = 16'h0000;
        repeat (80) @(negedge clk);
        total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL pressA_release: got held=%b required 0", kp.key_held); end
        s0 = strobes;
        exp_q.push_back(4'hD);
        pressed = 16'h8000;
        repeat (96) @(negedge clk);
        total++; if (strobes - s0 != 1) begin bad++; $display("FAIL pressD_count: got %0d strobes required 1", strobes - s0); end
        total++; if (kp.key_code !== 4'hD || kp.key_held !== 1'b1) begin bad++; $display("FAIL pressD_state: got code=%0h held=%b required d 1", kp.key_code, kp.key_held); end
    endtask

    task automatic test_reset_mid();
        int s0, first_n;
        do_reset();
        s0 = strobes;
        pressed = 16'h0100;
        repeat (40) @(negedge clk);
        total++; if (strobes != s0) begin bad++; $display("FAIL mid_pre_reset: got %0d strobes required 0", strobes - s0); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (kp.cols !== 4'b1110) begin bad++; $display("FAIL mid_reset_cols: got %b required 1110", kp.cols); end
        total++; if (kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin bad++; $display("FAIL mid_reset_flags: got valid=%b held=%b required 0 0", kp.key_valid, kp.key_held); end
        total++; if (kp.key_code !== 4'h0) begin bad++; $display("FAIL mid_reset_code: got %0h required 0", kp.key_code); end
        rst = 1'b0;
        first_n = -1;
        exp_q.push_back(4'h7);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (kp.key_valid && first_n < 0) first_n = n;
        end
        total++; if (first_n != 49) begin bad++; $display("FAIL mid_redebounce: got cycle %0d required 49", first_n); end
        total++; if (kp.key_code !== 4'h7) begin bad++; $display("FAIL mid_code: got %0h required 7", kp.key_code); end
        pressed = 16'h0000;
        repeat (80) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        pressed = 16'h0000;
        total = 0;
        bad = 0;
        strobes = 0;
        prev_valid = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_release_repress();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d expected strobes outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 hexadecimal matrix keypad by driving one column low at a time and sampling the four row lines.
- Debounces the result and emits one 4-bit hex code with a single-cycle valid strobe per key press.
- Sits on the input side of the board I/O, alongside the time-multiplexed 7-segment display path; typically feeds the hex decoder/display chain.

Parameters:
- SCAN_DIV, 100000, Clock cycles spent on each column (dwell). Legal range >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release. Legal range >= 2.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- rows  in  4  keypad row lines, active-low (pulled up externally), asynchronous to Clock.
- cols  out  4  keypad column drives, active-low, exactly one bit low at any time.
- key_code  out  4  hex code of the last accepted key; holds its value until the next accepted press.
- key_valid  out  1  one-cycle strobe when a new key is accepted.
- key_held  out  1  high from acceptance until the release is debounced.

Behaviour:
- Reset values: cols=4'b1110 (column 0), dwell counter=0, column index=0, FSM=IDLE, debounce count=0, key_code=0, key_valid=0, key_held=0.
- Synchronizer: rows pass through a 2-flop synchronizer before any use.
- Dwell counter: counts 0..SCAN_DIV-1, then wraps.
  - On the cycle where dwell==SCAN_DIV-1, the synchronized rows are sampled for the current column.
  - On the same edge, the column index advances (3 wraps to 0) and cols updates.
  - A full scan is 4*SCAN_DIV cycles.
- Scan accumulation: across columns 0..3, count the asserted (low) row bits and record the (row, col) of the asserted key.
  - Scan result at the column-3 sample is NONE (0 keys), SINGLE(K) (exactly 1 key), or MULTI (2 or more keys).
  - The accumulator clears for the next scan.
- Key map, by row r / col c:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D (* = E, # = F)
- Scan-result evaluation: the FSM evaluates the scan result on the cycle after the column-3 sample edge. All outputs are registered.
- FSM states and transitions:
  - IDLE:
    - SINGLE(K): cand=K, cnt=1, go to DEBOUNCE.
    - NONE or MULTI: stay.
  - DEBOUNCE:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS: go to PRESSED, key_code=cand, key_valid=1 for exactly one cycle, key_held=1.
    - Any other result: go to IDLE, cnt=0.
  - PRESSED:
    - NONE: cnt=1, go to RELEASE.
    - SINGLE(cand): stay.
    - SINGLE(other) or MULTI: stay, with no new event (no rollover).
  - RELEASE:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_SCANS: go to IDLE, key_held=0.
    - Any key seen: go back to PRESSED, cnt=0, no new key_valid.
- Press latency: first clean scan to key_valid is DEBOUNCE_SCANS scans, i.e. (DEBOUNCE_SCANS-1)*4*SCAN_DIV cycles after the first qualifying evaluation.
- Counter width: cnt saturates at DEBOUNCE_SCANS and never wraps.
- Reset mid-operation: all state returns to reset values on the next edge and any pending press is discarded. A key still held after reset is re-debounced from IDLE and produces a fresh key_valid.
- Simultaneous events: Reset has priority over all scan and FSM updates.

Test Plan:
Bench uses SCAN_DIV=4 and DEBOUNCE_SCANS=3 (scan = 16 cycles). The row model drives row r low only while the pressed key's column is driven low.
- Idle after reset, no key -> cols cycles 1110,1101,1011,0111 every 4 cycles; key_valid=0; key_held=0; key_code=0.
- Hold key '5' (r1,c1) steady -> exactly one key_valid, one cycle wide, after the 3rd clean scan evaluation; key_code=4'h5; key_held=1 for as long as the key is held.
- Bounce: '9' present for 2 scans, absent for 1, then steady -> no strobe until 3 consecutive clean scans after the gap; key_code=4'h9.
- Multi-key: hold '1' and '2' together -> no key_valid. Then hold '#' (r3,c2) while '5' is still held -> no second strobe. After full release, key_held drops 3 scans after the first NONE scan.
- Release/re-press: release 'A', re-press during RELEASE after 1 NONE scan -> returns to PRESSED with no new strobe. A full release followed by a press of 'D' -> new strobe with key_code=4'hD.
- Reset asserted mid-DEBOUNCE with '7' held -> outputs return to reset values next edge. '7' kept held -> key_valid after 3 clean scans, key_code=4'h7.
